sqw_burst_sequencer: RTL and testbench
======================================

SQW_BURST_SEQUENCER -- requirements
Module: sqw_burst_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 5, meaning clocks per 100 ns time unit at 50 MHz.
REQ-002 SHALL have parameter DEPTH, default 4, meaning number of segment table entries.
REQ-003 SHALL have port clk, input, 1, clock.
REQ-004 SHALL have port clr, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1, begin burst when idle.
REQ-006 SHALL have port stop, input, 1, abort burst.
REQ-007 SHALL have port wr_en, input, 1, table write strobe.
REQ-008 SHALL have port wr_addr, input, 2, table entry index.
REQ-009 SHALL have port wr_m, input, 4, high-time in 100 ns units.
REQ-010 SHALL have port wr_n, input, 4, low-time in 100 ns units.
REQ-011 SHALL have port wr_rep, input, 8, period count.
REQ-012 SHALL have port seg_last, input, 2, index of final entry used, sampled at start.
REQ-013 SHALL have port waveform, output, 1, registered square wave.
REQ-014 SHALL have port busy, output, 1, burst in progress.
REQ-015 SHALL have port done, output, 1, one-cycle pulse on normal completion.
REQ-016 SHALL have port seg_idx, output, 2, active entry index.

Function
REQ-017 SHALL write {wr_m, wr_n, wr_rep} into entry wr_addr on a wr_en clock only while busy=0; writes while busy=1 SHALL be ignored.
REQ-018 SHALL implement states IDLE, HIGH, LOW; transitions IDLE->HIGH/LOW on start, HIGH->LOW, LOW->HIGH, HIGH/LOW->IDLE on completion or stop.
REQ-019 SHALL treat an entry as empty when m=0 and n=0, or when rep=0; empty entries are skipped with zero clocks.
REQ-020 SHALL, on start sampled at edge k in IDLE, select the first non-empty entry in 0..seg_last, assert busy and drive the first phase from edge k+1.
REQ-021 SHALL hold waveform=1 for exactly m*TICK_DIV clocks and waveform=0 for exactly n*TICK_DIV clocks per period; m=0 skips HIGH, n=0 skips LOW.
REQ-022 SHALL repeat each entry rep times, then switch to the next non-empty entry at an index greater than the current one, up to seg_last, with no gap or extra clock between segments.
REQ-023 SHALL, after the last period of the last non-empty entry, enter IDLE, drive waveform=0, deassert busy, and pulse done for exactly one clock on the same edge.
REQ-024 SHALL, if no entry in 0..seg_last is non-empty at start, stay IDLE with busy=0 and pulse done at edge k+1.
REQ-025 SHALL, on stop at any edge while busy, enter IDLE on that edge with waveform=0 and busy=0, and SHALL NOT pulse done.
REQ-026 SHALL give stop priority over start when both are asserted in the same cycle, and SHALL ignore start while busy=1.
REQ-027 SHALL compute phase lengths as 4-bit x TICK_DIV into a counter wide enough for 15*TICK_DIV (7 bits for the default), and the period counter SHALL be 8 bits.
REQ-028 SHALL drive seg_idx with the active entry while busy=1, and hold its last value while in IDLE.

Reset
REQ-029 SHALL, on clr=1, immediately force state IDLE, waveform=0, busy=0, done=0, seg_idx=0, and all counters to 0.
REQ-030 SHALL, on clr=1, clear all table entries to 0 (empty).
REQ-031 SHALL, on clr asserted mid-burst, abort the burst without a done pulse.

Configuration
REQ-032 SHALL, with SQW_SEQ_LOOP_EN defined, wrap from the last non-empty entry back to the first non-empty entry with no gap, never pulse done except per REQ-024, and end only on stop or clr.
REQ-033 SHALL, without SQW_SEQ_LOOP_EN, complete per REQ-023.

Structure
REQ-034 SHALL place TICK_DIV default, field widths (M_W=4, N_W=4, REP_W=8, CNT_W=7) and state encodings in shared package sqw_pkg.
REQ-035 SHALL use one sub-module, sqw_period_unit, that generates one m/n period from loaded values and emits period_done on its final clock.

Verification
REQ-036 SHALL verify that entry0={m=2, n=3, rep=2} with seg_last=0 and start gives a 10/15 clock high/low pattern twice, then done 50 clocks after the first high.
REQ-037 SHALL verify that entry0={1,1,1}, entry1={0,0,5} (empty) and entry2={3,0,1} with seg_last=2 gives 5 high, 5 low, 15 high, no gap, and seg_idx steps 0->2.
REQ-038 SHALL verify that stop at clock 7 of a {4,4,3} burst drives waveform=0 and busy=0 next edge with no done, and that a subsequent start restarts from entry 0.
REQ-039 SHALL verify that all entries empty with start gives done one clock later with busy never asserted, and that a wr_en during a burst leaves the table unchanged.
REQ-040 SHALL verify that clr mid-HIGH forces waveform=0 asynchronously and clears the table; with SQW_SEQ_LOOP_EN, {1,1,2} loops continuously for 100 periods with no done pulse.

Source files
------------

// File: rtl/sqw_pkg.sv
// Shared definitions for the square-wave burst sequencer: field widths,
// the phase state encoding, the segment table entry layout and a helper
// that tells whether an entry contributes any clocks to a burst.
package sqw_pkg;

  localparam int TICK_DIV_DEF = 5;
  localparam int M_W          = 4;
  localparam int N_W          = 4;
  localparam int REP_W        = 8;
  localparam int CNT_W        = 7;
  localparam int IDX_W        = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } sqw_state_e;

  typedef struct packed {
    logic [M_W-1:0]   m;
    logic [N_W-1:0]   n;
    logic [REP_W-1:0] rep;
  } sqw_entry_t;

  localparam sqw_entry_t ENTRY_NONE = '{m: 4'd0, n: 4'd0, rep: 8'd0};

  // An entry is skipped when it has no high or low time, or no periods.
  function automatic logic entry_empty(input sqw_entry_t e);
    return ((e.m == 4'd0) && (e.n == 4'd0)) || (e.rep == 8'd0);
  endfunction

endpackage

// File: rtl/sqw_period_unit.sv
// Generates a single high/low period from lengths loaded on 'load'.
// period_done flags the final clock of the period so the sequencer can
// load the next period on the same edge without a gap.
module sqw_period_unit
  import sqw_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int PH_W     = CNT_W
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           abort,
  input  logic           load,
  input  logic [M_W-1:0] m,
  input  logic [N_W-1:0] n,
  output logic           wave,
  output logic           period_done
);

  localparam logic [PH_W-1:0] ZERO = PH_W'(0);
  localparam logic [PH_W-1:0] ONE  = PH_W'(1);
  localparam logic [PH_W-1:0] DIV  = PH_W'(TICK_DIV);

  sqw_state_e      state_r;
  logic [PH_W-1:0] cnt_r;
  logic [PH_W-1:0] n_len_r;
  logic            wave_r;
  logic [PH_W-1:0] m_len_s;
  logic [PH_W-1:0] n_len_s;

  assign m_len_s = PH_W'(m) * DIV;
  assign n_len_s = PH_W'(n) * DIV;
  assign wave    = wave_r;

  // Final clock of a period: end of HIGH with no LOW phase, or end of LOW.
  always_comb begin
    period_done = 1'b0;
    case (state_r)
      ST_HIGH: period_done = (cnt_r == ZERO) && (n_len_r == ZERO);
      ST_LOW:  period_done = (cnt_r == ZERO);
      default: period_done = 1'b0;
    endcase
  end

  // Phase state and down-counter; a load restarts the period immediately.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r <= ST_IDLE;
      cnt_r   <= ZERO;
      n_len_r <= ZERO;
      wave_r  <= 1'b0;
    end else if (abort) begin
      state_r <= ST_IDLE;
      cnt_r   <= ZERO;
      n_len_r <= ZERO;
      wave_r  <= 1'b0;
    end else if (load) begin
      n_len_r <= n_len_s;
      if (m_len_s != ZERO) begin
        state_r <= ST_HIGH;
        cnt_r   <= m_len_s - ONE;
        wave_r  <= 1'b1;
      end else begin
        state_r <= ST_LOW;
        cnt_r   <= n_len_s - ONE;
        wave_r  <= 1'b0;
      end
    end else begin
      case (state_r)
        ST_HIGH: begin
          if (cnt_r == ZERO) begin
            if (n_len_r != ZERO) begin
              state_r <= ST_LOW;
              cnt_r   <= n_len_r - ONE;
            end else begin
              state_r <= ST_IDLE;
            end
            wave_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r - ONE;
          end
        end
        ST_LOW: begin
          if (cnt_r == ZERO) begin
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - ONE;
          end
          wave_r <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= ZERO;
          wave_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/sqw_burst_sequencer.sv
// Square-wave burst sequencer: plays entries 0..seg_last of a small segment
// table, each entry giving m high / n low time units repeated rep times.
// Start is sampled in idle; the first phase appears one clock later.
// Optional build macro SQW_SEQ_LOOP_EN: wrap to the first non-empty entry
// after the last one instead of completing, ending only on stop or clr.
module sqw_burst_sequencer
  import sqw_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int DEPTH    = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             stop,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [M_W-1:0]   wr_m,
  input  logic [N_W-1:0]   wr_n,
  input  logic [REP_W-1:0] wr_rep,
  input  logic [IDX_W-1:0] seg_last,
  output logic             waveform,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] seg_idx
);

  localparam int PH_CALC = $clog2(((1 << M_W) - 1) * TICK_DIV + 1);
  localparam int PH_W    = (PH_CALC > CNT_W) ? PH_CALC : CNT_W;

  sqw_entry_t       tab_r [DEPTH];
  logic             launch_r;
  logic [IDX_W-1:0] seg_last_r;
  logic [IDX_W-1:0] cur_idx_r;
  logic [REP_W-1:0] rep_cnt_r;
  logic             busy_r;
  logic             done_r;

  logic             first_found_s;
  logic [IDX_W-1:0] first_idx_s;
  logic             next_found_s;
  logic [IDX_W-1:0] next_idx_s;
  logic             load_s;
  logic [IDX_W-1:0] load_idx_s;
  logic             same_s;
  logic             finish_s;
  logic             period_done_s;
  logic             wave_s;

  assign waveform = wave_s;
  assign busy     = busy_r;
  assign done     = done_r;
  assign seg_idx  = cur_idx_r;

  // Segment table: written only outside a burst, emptied by clr.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        tab_r[i] <= ENTRY_NONE;
      end
    end else if (wr_en && !busy_r && (int'(wr_addr) < DEPTH)) begin
      tab_r[wr_addr] <= '{m: wr_m, n: wr_n, rep: wr_rep};
    end else begin
      tab_r <= tab_r;
    end
  end

  // Lowest non-empty entry in 0..seg_last, and lowest above the active one.
  always_comb begin
    first_found_s = 1'b0;
    first_idx_s   = 2'd0;
    next_found_s  = 1'b0;
    next_idx_s    = 2'd0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if ((i <= int'(seg_last_r)) && !entry_empty(tab_r[i])) begin
        first_found_s = 1'b1;
        first_idx_s   = IDX_W'(i);
      end else begin
      end
      if ((i > int'(cur_idx_r)) && (i <= int'(seg_last_r)) && !entry_empty(tab_r[i])) begin
        next_found_s = 1'b1;
        next_idx_s   = IDX_W'(i);
      end else begin
      end
    end
  end

  // Decide what follows a launch or the last clock of a period.
  always_comb begin
    load_s     = 1'b0;
    load_idx_s = cur_idx_r;
    same_s     = 1'b0;
    finish_s   = 1'b0;
    if (stop) begin
      load_s = 1'b0;
    end else if (launch_r) begin
      if (first_found_s) begin
        load_s     = 1'b1;
        load_idx_s = first_idx_s;
      end else begin
        finish_s = 1'b1;
      end
    end else if (busy_r && period_done_s) begin
      if (rep_cnt_r > 8'd1) begin
        load_s = 1'b1;
        same_s = 1'b1;
      end else if (next_found_s) begin
        load_s     = 1'b1;
        load_idx_s = next_idx_s;
      end else begin
`ifdef SQW_SEQ_LOOP_EN
        load_s     = 1'b1;
        load_idx_s = first_idx_s;
`else
        finish_s = 1'b1;
`endif
      end
    end else begin
      load_s = 1'b0;
    end
  end

  // Burst control: launch, segment/repeat bookkeeping, completion and abort.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      launch_r   <= 1'b0;
      seg_last_r <= 2'd0;
      cur_idx_r  <= 2'd0;
      rep_cnt_r  <= 8'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (stop) begin
        launch_r <= 1'b0;
        busy_r   <= 1'b0;
      end else if (launch_r || (busy_r && period_done_s)) begin
        launch_r <= 1'b0;
        if (load_s) begin
          busy_r    <= 1'b1;
          cur_idx_r <= load_idx_s;
          rep_cnt_r <= same_s ? (rep_cnt_r - 8'd1) : tab_r[load_idx_s].rep;
        end else begin
          busy_r <= 1'b0;
          done_r <= finish_s;
        end
      end else if (!busy_r && start) begin
        launch_r   <= 1'b1;
        seg_last_r <= seg_last;
      end else begin
        launch_r <= launch_r;
      end
    end
  end

  sqw_period_unit #(
    .TICK_DIV (TICK_DIV),
    .PH_W     (PH_W)
  ) u_period (
    .clk         (clk),
    .clr         (clr),
    .abort       (stop),
    .load        (load_s),
    .m           (tab_r[load_idx_s].m),
    .n           (tab_r[load_idx_s].n),
    .wave        (wave_s),
    .period_done (period_done_s)
  );

endmodule

// File: tb/tb_sqw_burst_sequencer.sv
// Self-checking bench for sqw_burst_sequencer. The reference model expands
// the table into a per-clock list of expected (level, entry) pairs.
module tb_sqw_burst_sequencer;

  localparam int TD = 5;

  logic       clk = 1'b0;
  logic       clr;
  logic       start;
  logic       stop;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_m;
  logic [3:0] wr_n;
  logic [7:0] wr_rep;
  logic [1:0] seg_last;
  logic       waveform;
  logic       busy;
  logic       done;
  logic [1:0] seg_idx;

  int checks = 0;
  int errors = 0;
  int mod_m [4];
  int mod_n [4];
  int mod_rep [4];
  int last_idx;
  bit exp_w [$];
  int exp_i [$];

  always #5 clk = ~clk;

  sqw_burst_sequencer #(.TICK_DIV(TD), .DEPTH(4)) dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .stop     (stop),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_m     (wr_m),
    .wr_n     (wr_n),
    .wr_rep   (wr_rep),
    .seg_last (seg_last),
    .waveform (waveform),
    .busy     (busy),
    .done     (done),
    .seg_idx  (seg_idx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int a, input int m, input int n, input int r);
    wr_en   = 1'b1;
    wr_addr = a[1:0];
    wr_m    = m[3:0];
    wr_n    = n[3:0];
    wr_rep  = r[7:0];
    tick();
    wr_en = 1'b0;
    mod_m[a]   = m;
    mod_n[a]   = n;
    mod_rep[a] = r;
  endtask

  // Expand the model table into the expected clock-by-clock burst.
  task automatic build_expected(input int sl);
    exp_w.delete();
    exp_i.delete();
    for (int i = 0; i <= sl; i++) begin
      if (!(((mod_m[i] == 0) && (mod_n[i] == 0)) || (mod_rep[i] == 0))) begin
        for (int r = 0; r < mod_rep[i]; r++) begin
          for (int c = 0; c < mod_m[i] * TD; c++) begin exp_w.push_back(1'b1); exp_i.push_back(i); end
          for (int c = 0; c < mod_n[i] * TD; c++) begin exp_w.push_back(1'b0); exp_i.push_back(i); end
        end
      end
    end
  endtask

  task automatic run_burst(input int sl, input int stop_after, input int laps, input bit poke);
    int total;
    int sz;
    bit stopped;
    build_expected(sl);
    sz    = exp_w.size();
    total = sz;
`ifdef SQW_SEQ_LOOP_EN
    total = sz * laps;
`endif
    seg_last = sl[1:0];
    start    = 1'b1;
    tick();
    start = 1'b0;
    chk("launch_busy", busy, 0);
    chk("launch_idx", seg_idx, last_idx);
    stopped = 1'b0;
    for (int j = 0; j < total; j++) begin
      if (j == stop_after) begin
        stopped = 1'b1;
        break;
      end
      if (poke && (j == 1)) begin
        wr_en = 1'b1; wr_addr = 2'd0; wr_m = 4'd1; wr_n = 4'd1; wr_rep = 8'd1;
      end
      start = (j == 2);
      tick();
      wr_en = 1'b0;
      start = 1'b0;
      chk("wave", waveform, exp_w[j % sz]);
      chk("busy", busy, 1);
      chk("seg_idx", seg_idx, exp_i[j % sz]);
      chk("no_done", done, 0);
      last_idx = exp_i[j % sz];
    end
`ifdef SQW_SEQ_LOOP_EN
    if (sz > 0) stopped = 1'b1;
`endif
    if (stopped) begin
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("stop_wave", waveform, 0);
      chk("stop_busy", busy, 0);
      chk("stop_done", done, 0);
      chk("stop_idx", seg_idx, last_idx);
      tick();
      chk("stop_done2", done, 0);
    end else begin
      tick();
      chk("end_done", done, 1);
      chk("end_busy", busy, 0);
      chk("end_wave", waveform, 0);
      chk("end_idx", seg_idx, last_idx);
      tick();
      chk("end_done_pulse", done, 0);
    end
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; stop = 1'b0; wr_en = 1'b0;
    wr_addr = 2'd0; wr_m = 4'd0; wr_n = 4'd0; wr_rep = 8'd0; seg_last = 2'd0;
    last_idx = 0;
    for (int i = 0; i < 4; i++) begin mod_m[i] = 0; mod_n[i] = 0; mod_rep[i] = 0; end
    #12;
    chk("rst_wave", waveform, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_idx", seg_idx, 0);
    clr = 1'b0;
    tick();

    // 10 high / 15 low twice, done 50 clocks after the first high.
    write_entry(0, 2, 3, 2);
    run_burst(0, -1, 1, 1'b0);

    // Empty middle entry skipped with no gap, index steps 0 -> 2.
    write_entry(0, 1, 1, 1);
    write_entry(1, 0, 0, 5);
    write_entry(2, 3, 0, 1);
    run_burst(2, -1, 1, 1'b0);

    // Stop at clock 7 with an ignored write, then restart from entry 0.
    write_entry(0, 4, 4, 3);
    run_burst(0, 6, 1, 1'b1);
    run_burst(0, -1, 1, 1'b0);

    // All entries empty: done one clock after start, never busy.
    write_entry(0, 0, 0, 3);
    write_entry(1, 2, 2, 0);
    write_entry(2, 0, 0, 0);
    write_entry(3, 5, 0, 0);
    run_burst(3, -1, 1, 1'b0);

    // Asynchronous clr in the middle of a high phase.
    write_entry(2, 3, 2, 1);
    seg_last = 2'd2;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre_clr_wave", waveform, 1);
    chk("pre_clr_idx", seg_idx, 2);
    #2 clr = 1'b1;
    #1;
    chk("clr_wave", waveform, 0);
    chk("clr_busy", busy, 0);
    chk("clr_idx", seg_idx, 0);
    chk("clr_done", done, 0);
    tick();
    clr = 1'b0;
    for (int i = 0; i < 4; i++) begin mod_m[i] = 0; mod_n[i] = 0; mod_rep[i] = 0; end
    last_idx = 0;
    run_burst(3, -1, 1, 1'b0);

    // {1,1,2}: 100 periods of continuous looping in the loop build.
    write_entry(0, 1, 1, 2);
    run_burst(0, -1, 50, 1'b0);

    // Randomised tables, ranges and occasional stops.
    for (int t = 0; t < 20; t++) begin
      for (int a = 0; a < 4; a++) begin
        write_entry(a, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      end
      run_burst($urandom_range(0, 3),
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : -1,
                2, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
